imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, UART bit rate; CPB = CLK_FREQ/BAUD clocks per bit, integer-truncated.
REQ-003 SHALL have parameter MAX_WORDS, default 2048, capacity of the instruction memory in 32-bit words.
REQ-004 SHALL have ports: i_clk  in  1  clock; the only clock.
REQ-005 SHALL have ports: i_reset  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: i_rx  in  1  UART serial input, idle high, 8N1, LSB first.
REQ-007 SHALL have ports: o_addr  out  32  word address into instruction memory.
REQ-008 SHALL have ports: o_wdata  out  32  write data.
REQ-009 SHALL have ports: o_bmask  out  4  byte-enable mask.
REQ-010 SHALL have ports: o_wren  out  1  write strobe.
REQ-011 SHALL have ports: o_busy  out  1  load in progress.
REQ-012 SHALL have ports: o_done  out  1  image loaded.
REQ-013 SHALL have ports: o_err  out  1  load failed.

Function
REQ-014 SHALL pass i_rx through a 2-flop synchronizer, with both flops resetting to 1, before any use.
REQ-015 UART receiver SHALL have states RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-016 RX_IDLE -> RX_START on a synchronized low level; RX_START SHALL sample at CPB/2 clocks; a low sample -> RX_DATA, a high sample -> RX_IDLE (glitch rejected, no error).
REQ-017 RX_DATA SHALL sample 8 bits, each CPB clocks apart, into an LSB-first shift register, then go to RX_STOP.
REQ-018 RX_STOP SHALL sample the stop bit after CPB clocks; a high sample SHALL emit a 1-cycle internal byte_valid pulse with the byte, a low sample SHALL flag a framing error; both paths return to RX_IDLE.
REQ-019 Loader FSM SHALL have states LEN0, LEN1, DATA, CSUM, DONE, ERR; reset state is LEN0.
REQ-020 LEN0/LEN1 SHALL capture a 16-bit word count N, little-endian (LEN0 low byte, LEN1 high byte).
REQ-021 After LEN1: N > MAX_WORDS -> ERR; N = 0 -> CSUM if the checksum is compiled in, otherwise DONE; any other N -> DATA.
REQ-022 DATA SHALL assemble 4 bytes into o_wdata little-endian (first byte to bits [7:0]).
REQ-023 One cycle after the 4th byte_valid, DATA SHALL pulse o_wren for exactly 1 cycle with o_bmask=4'hF and o_addr = word index; the first word has index 0.
REQ-024 The word index SHALL increment after each write; after word N-1 is written the FSM goes to CSUM if compiled in, otherwise to DONE.
REQ-025 A framing error in any state other than DONE SHALL force ERR.
REQ-026 DONE and ERR SHALL be sticky until reset; received bytes in these states SHALL be ignored and o_wren SHALL stay 0.
REQ-027 o_busy SHALL be 1 from the first accepted start bit until entry to DONE or ERR.
REQ-028 o_done SHALL be 1 only in DONE; o_err SHALL be 1 only in ERR.
REQ-029 o_wren SHALL never pulse in states other than DATA.

Reset
REQ-030 On i_reset=0 at a clock edge, all state, counters and outputs SHALL clear: o_addr=0, o_wdata=0, o_bmask=0, o_wren=0, o_busy=0, o_done=0, o_err=0, receiver in RX_IDLE, loader in LEN0.
REQ-031 A reset mid-frame or mid-word SHALL discard the partial byte or word with no write issued, and the next load SHALL start again at LEN0.

Configuration
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN defined: the CSUM state SHALL be built in.
REQ-033 With the macro defined, CSUM SHALL receive one byte and compare it with the 8-bit sum (mod 256) of all payload data bytes; a match -> DONE, a mismatch -> ERR.
REQ-034 Macro IMEM_LOADER_CHECKSUM_EN undefined: no checksum logic SHALL exist, and the FSM goes from the last word straight to DONE.

Verification
REQ-035 Scenario: CLK_FREQ=1_000_000, BAUD=100_000; send 01 00 78 56 34 12 -> one o_wren pulse with o_addr=0, o_wdata=32'h12345678, o_bmask=4'hF, then o_done=1 and o_busy=0.
REQ-036 Scenario: N=3 with words 0x00000013, 0x00100093, 0xFFF00113 -> writes to o_addr 0, 1, 2 in order, each o_wren exactly 1 cycle wide.
REQ-037 Scenario: send 01 08 with MAX_WORDS=2048 (N=2049) -> o_err=1, no o_wren pulse.
REQ-038 Scenario: hold the stop bit low on the 3rd byte -> o_err=1, no write issued; later bytes are ignored.
REQ-039 Scenario: assert i_reset=0 after 2 data bytes, then resend a full N=1 image -> exactly one write, to o_addr=0, with the correct data.
REQ-040 Scenario (IMEM_LOADER_CHECKSUM_EN): N=1, word bytes 01 02 03 04, checksum 0x0A -> o_done=1; checksum 0x0B -> o_err=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: UART 8N1 boot loader writing a length-prefixed little-endian image into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 sum byte after the payload.
module imem_loader #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int MAX_WORDS = 2048
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_bmask,
    output logic        o_wren,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);
    localparam int CPB    = CLK_FREQ / BAUD;
    localparam int HALF   = (CPB / 2 > 0) ? CPB / 2 : 1;
    localparam int CPB_M1 = (CPB > 1) ? CPB - 1 : 0;
    localparam int CW     = (CPB > 1) ? $clog2(CPB + 1) : 1;
    localparam logic [CW-1:0] CNT_BIT  = CW'(CPB_M1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [31:0]   MAX_W    = 32'(MAX_WORDS);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        LD_LEN0,
        LD_LEN1,
        LD_DATA,
        LD_CSUM,
        LD_DONE,
        LD_ERR
    } ld_state_t;
    localparam ld_state_t LD_AFTER_DATA = LD_CSUM;
`else
    typedef enum logic [2:0] {
        LD_LEN0,
        LD_LEN1,
        LD_DATA,
        LD_DONE,
        LD_ERR
    } ld_state_t;
    localparam ld_state_t LD_AFTER_DATA = LD_DONE;
`endif

    // ---------------- input synchronizer ----------------
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ---------------- UART receiver ----------------
    rx_state_t     r_rx_state;
    rx_state_t     w_rx_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic          r_byte_valid;
    logic          w_byte_valid;
    logic          r_frame_err;
    logic          w_frame_err;
    logic          r_start_ok;
    logic          w_start_ok;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rx_state   <= RX_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_start_ok   <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_next;
            r_cnt        <= w_cnt_next;
            r_bit_idx    <= w_bit_idx_next;
            r_shift      <= w_shift_next;
            r_byte_valid <= w_byte_valid;
            r_frame_err  <= w_frame_err;
            r_start_ok   <= w_start_ok;
        end
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_cnt_next      = r_cnt + 1'b1;
        w_bit_idx_next  = r_bit_idx;
        w_shift_next    = r_shift;
        w_byte_valid    = 1'b0;
        w_frame_err     = 1'b0;
        w_start_ok      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_cnt_next = '0;
                if (!r_rx_sync) begin
                    w_rx_state_next = RX_START;
                end
            end
            RX_START: begin
                // Mid-start-bit recheck rejects short glitches on the idle line.
                if (r_cnt == CNT_HALF) begin
                    w_cnt_next = '0;
                    if (!r_rx_sync) begin
                        w_rx_state_next = RX_DATA;
                        w_bit_idx_next  = '0;
                        w_start_ok      = 1'b1;
                    end else begin
                        w_rx_state_next = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (r_cnt == CNT_BIT) begin
                    w_cnt_next   = '0;
                    w_shift_next = {r_rx_sync, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_rx_state_next = RX_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (r_cnt == CNT_BIT) begin
                    w_cnt_next      = '0;
                    w_rx_state_next = RX_IDLE;
                    if (r_rx_sync) begin
                        w_byte_valid = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
            end
            default: begin
                w_rx_state_next = RX_IDLE;
            end
        endcase
    end

    // ---------------- loader FSM ----------------
    ld_state_t   r_ld_state;
    ld_state_t   w_ld_next;
    logic [15:0] r_len;
    logic [15:0] w_len_next;
    logic [1:0]  r_bidx;
    logic [1:0]  w_bidx_next;
    logic [31:0] r_wdata;
    logic [31:0] w_wdata_next;
    logic [15:0] r_widx;
    logic [15:0] w_widx_next;
    logic        r_wren;
    logic        w_wren_next;
    logic [3:0]  r_bmask;
    logic [3:0]  w_bmask_next;
    logic [31:0] r_addr;
    logic [31:0] w_addr_next;
    logic        r_busy;
    logic        w_busy_next;
    logic [15:0] w_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
    logic [7:0]  w_csum_next;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_ld_state <= LD_LEN0;
            r_len      <= '0;
            r_bidx     <= '0;
            r_wdata    <= '0;
            r_widx     <= '0;
            r_wren     <= 1'b0;
            r_bmask    <= '0;
            r_addr     <= '0;
            r_busy     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_ld_state <= w_ld_next;
            r_len      <= w_len_next;
            r_bidx     <= w_bidx_next;
            r_wdata    <= w_wdata_next;
            r_widx     <= w_widx_next;
            r_wren     <= w_wren_next;
            r_bmask    <= w_bmask_next;
            r_addr     <= w_addr_next;
            r_busy     <= w_busy_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= w_csum_next;
`endif
        end
    end

    assign w_n = {r_shift, r_len[7:0]};

    always_comb begin
        w_ld_next    = r_ld_state;
        w_len_next   = r_len;
        w_bidx_next  = r_bidx;
        w_wdata_next = r_wdata;
        w_widx_next  = r_widx;
        w_wren_next  = 1'b0;
        w_bmask_next = 4'h0;
        w_addr_next  = r_addr;
        w_busy_next  = r_busy;
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_csum_next  = r_csum;
`endif
        if (r_start_ok && r_ld_state != LD_DONE && r_ld_state != LD_ERR) begin
            w_busy_next = 1'b1;
        end
        case (r_ld_state)
            LD_LEN0: begin
                if (r_byte_valid) begin
                    w_len_next[7:0] = r_shift;
                    w_ld_next       = LD_LEN1;
                end
            end
            LD_LEN1: begin
                if (r_byte_valid) begin
                    w_len_next[15:8] = r_shift;
                    if (32'(w_n) > MAX_W) begin
                        w_ld_next = LD_ERR;
                    end else if (w_n == 16'd0) begin
                        w_ld_next = LD_AFTER_DATA;
                    end else begin
                        w_ld_next = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                // The write cycle itself advances the word index and decides the exit.
                if (r_wren) begin
                    w_widx_next = r_widx + 16'd1;
                    if (r_widx == r_len - 16'd1) begin
                        w_ld_next = LD_AFTER_DATA;
                    end
                end else if (r_byte_valid) begin
                    case (r_bidx)
                        2'd0:    w_wdata_next[7:0]   = r_shift;
                        2'd1:    w_wdata_next[15:8]  = r_shift;
                        2'd2:    w_wdata_next[23:16] = r_shift;
                        default: w_wdata_next[31:24] = r_shift;
                    endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_csum_next = r_csum + r_shift;
`endif
                    w_bidx_next = r_bidx + 2'd1;
                    if (r_bidx == 2'd3) begin
                        w_wren_next  = 1'b1;
                        w_bmask_next = 4'hF;
                        w_addr_next  = {16'd0, r_widx};
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            LD_CSUM: begin
                if (r_byte_valid) begin
                    w_ld_next = (r_shift == r_csum) ? LD_DONE : LD_ERR;
                end
            end
`endif
            LD_DONE: begin
                w_ld_next = LD_DONE;
            end
            LD_ERR: begin
                w_ld_next = LD_ERR;
            end
            default: begin
                w_ld_next = LD_ERR;
            end
        endcase
        if (r_frame_err && r_ld_state != LD_DONE) begin
            w_ld_next    = LD_ERR;
            w_wren_next  = 1'b0;
            w_bmask_next = 4'h0;
        end
        if (w_ld_next == LD_DONE || w_ld_next == LD_ERR) begin
            w_busy_next = 1'b0;
        end
    end

    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_bmask = r_bmask;
    assign o_wren  = r_wren;
    assign o_busy  = r_busy;
    assign o_done  = (r_ld_state == LD_DONE);
    assign o_err   = (r_ld_state == LD_ERR);

endmodule
